// File: rtl/fft_pkg.sv
// Shared widths, twiddle fixed-point constants and sample type for the FFT/IFFT datapath.
package fft_pkg;

   localparam int DW       = 16;
   localparam int TW       = 16;
   localparam int OW       = 18;
   localparam int TW_FRAC  = 14;
   localparam int TW_ROUND = 8192;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

endpackage

// File: rtl/ifft_butterfly_stage_cmult_conj.sv
// Two-stage multiply of a difference term by conj(W), with Q1.14 rounding and output saturation.
// Optional halving of the saturated result is enabled by IFFT_SCALE_EN.
module cmult_conj #(
   parameter int DIFF_W = 17,
   parameter int TWID_W = 16,
   parameter int OUT_W  = 18
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     adv_i,
   input  logic signed [DIFF_W-1:0] dr_i,
   input  logic signed [DIFF_W-1:0] di_i,
   input  logic signed [TWID_W-1:0] wr_i,
   input  logic signed [TWID_W-1:0] wi_i,
   output logic signed [OUT_W-1:0]  re_o,
   output logic signed [OUT_W-1:0]  im_o,
   output logic                     clip_o
);
   import fft_pkg::*;

   localparam int PW = DIFF_W + TWID_W;
   localparam int AW = PW + 1;
   localparam logic signed [AW-1:0] OMAX = AW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [AW-1:0] OMIN = ~OMAX;

   logic signed [PW-1:0]    rr_q, ii_q, ir_q, ri_q;
   logic signed [AW-1:0]    prSum, piSum, prRnd, piRnd;
   logic signed [OUT_W-1:0] reSat, imSat, re_d, im_d, re_q, im_q;
   logic                    reClip, imClip;
`ifdef IFFT_SCALE_EN
   logic [OUT_W:0]          reWide, imWide;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= '0;
         ii_q <= '0;
         ir_q <= '0;
         ri_q <= '0;
         re_q <= '0;
         im_q <= '0;
      end else if (adv_i) begin
         rr_q <= PW'(dr_i) * PW'(wr_i);
         ii_q <= PW'(di_i) * PW'(wi_i);
         ir_q <= PW'(di_i) * PW'(wr_i);
         ri_q <= PW'(dr_i) * PW'(wi_i);
         re_q <= re_d;
         im_q <= im_d;
      end
   end

   // Conjugating W flips the sign of the cross terms relative to a plain complex multiply.
   always_comb begin
      prSum  = AW'(rr_q) + AW'(ii_q);
      piSum  = AW'(ir_q) - AW'(ri_q);
      prRnd  = (prSum + AW'(TW_ROUND)) >>> TW_FRAC;
      piRnd  = (piSum + AW'(TW_ROUND)) >>> TW_FRAC;
      reClip = (prRnd > OMAX) || (prRnd < OMIN);
      imClip = (piRnd > OMAX) || (piRnd < OMIN);
      reSat  = reClip ? (prRnd[AW-1] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0]) : prRnd[OUT_W-1:0];
      imSat  = imClip ? (piRnd[AW-1] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0]) : piRnd[OUT_W-1:0];
`ifdef IFFT_SCALE_EN
      reWide = {reSat[OUT_W-1], reSat} + {{OUT_W{1'b0}}, 1'b1};
      imWide = {imSat[OUT_W-1], imSat} + {{OUT_W{1'b0}}, 1'b1};
      re_d   = reWide[OUT_W:1];
      im_d   = imWide[OUT_W:1];
`else
      re_d   = reSat;
      im_d   = imSat;
`endif
      clip_o = reClip | imClip;
   end

   assign re_o = re_q;
   assign im_o = im_q;

endmodule

// File: rtl/ifft_butterfly_stage.sv
// Pipelined radix-2 DIF inverse butterfly: out1 = a+b, out2 = (a-b)*conj(W), 3-stage valid/ready.
// Define IFFT_SCALE_EN to halve every output component with rounding.
module ifft_butterfly_stage #(
   parameter int DW = 16,
   parameter int TW = 16,
   parameter int OW = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in1_real,
   input  logic signed [DW-1:0] in1_imag,
   input  logic signed [DW-1:0] in2_real,
   input  logic signed [DW-1:0] in2_imag,
   input  logic signed [TW-1:0] twiddle_real,
   input  logic signed [TW-1:0] twiddle_imag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] out1_real,
   output logic signed [OW-1:0] out1_imag,
   output logic signed [OW-1:0] out2_real,
   output logic signed [OW-1:0] out2_imag,
   output logic                 sat
);
   import fft_pkg::*;

   localparam int SW = DW + 1;

   logic                 adv, clip;
   logic                 v1_q, v2_q, v3_q;
   logic                 sat_d, sat_q;
   logic signed [SW-1:0] sr_d, si_d, dr_d, di_d;
   logic signed [SW-1:0] sr_q, si_q, dr_q, di_q, s2r_q, s2i_q;
   logic signed [TW-1:0] wr_q, wi_q;
   logic signed [OW-1:0] o1r_d, o1i_d, o1r_q, o1i_q;
`ifdef IFFT_SCALE_EN
   logic [OW:0]          o1rWide, o1iWide;
`endif

   // One enable for the whole pipe: a stalled output freezes every stage, bubbles included.
   assign adv      = !v3_q || out_ready;
   assign in_ready = adv;

   always_comb begin
      sr_d  = SW'(in1_real) + SW'(in2_real);
      si_d  = SW'(in1_imag) + SW'(in2_imag);
      dr_d  = SW'(in1_real) - SW'(in2_real);
      di_d  = SW'(in1_imag) - SW'(in2_imag);
`ifdef IFFT_SCALE_EN
      o1rWide = (OW+1)'(s2r_q) + (OW+1)'(1);
      o1iWide = (OW+1)'(s2i_q) + (OW+1)'(1);
      o1r_d   = o1rWide[OW:1];
      o1i_d   = o1iWide[OW:1];
`else
      o1r_d   = OW'(s2r_q);
      o1i_d   = OW'(s2i_q);
`endif
      sat_d = sat_q | (adv & v2_q & clip);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         sat_q <= 1'b0;
         sr_q  <= '0;
         si_q  <= '0;
         dr_q  <= '0;
         di_q  <= '0;
         wr_q  <= '0;
         wi_q  <= '0;
         s2r_q <= '0;
         s2i_q <= '0;
         o1r_q <= '0;
         o1i_q <= '0;
      end else begin
         sat_q <= sat_d;
         if (adv) begin
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            sr_q  <= sr_d;
            si_q  <= si_d;
            dr_q  <= dr_d;
            di_q  <= di_d;
            wr_q  <= twiddle_real;
            wi_q  <= twiddle_imag;
            s2r_q <= sr_q;
            s2i_q <= si_q;
            o1r_q <= o1r_d;
            o1i_q <= o1i_d;
         end
      end
   end

   cmult_conj #(
      .DIFF_W (SW),
      .TWID_W (TW),
      .OUT_W  (OW)
   ) uMult (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (adv),
      .dr_i   (dr_q),
      .di_i   (di_q),
      .wr_i   (wr_q),
      .wi_i   (wi_q),
      .re_o   (out2_real),
      .im_o   (out2_imag),
      .clip_o (clip)
   );

   assign out_valid = v3_q;
   assign out1_real = o1r_q;
   assign out1_imag = o1i_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_ifft_butterfly_stage.sv
// Self-checking bench for ifft_butterfly_stage: directed steps plus randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_ifft_butterfly_stage;

   typedef struct {
      longint o1r;
      longint o1i;
      longint o2r;
      longint o2i;
      bit     clip;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_ready, out_valid, out_ready, sat;
   logic signed [15:0] in1_real, in1_imag, in2_real, in2_imag;
   logic signed [15:0] twiddle_real, twiddle_imag;
   logic signed [17:0] out1_real, out1_imag, out2_real, out2_imag;
   logic signed [17:0] held1r, held1i, held2r, held2i;

   exp_t expQ[$];
   int   vectors  = 0;
   int   misses   = 0;
   int   rxCount  = 0;
   bit   expSat   = 1'b0;
   bit   holdValid = 1'b0;
   bit   stallPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   ifft_butterfly_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in1_real     (in1_real),
      .in1_imag     (in1_imag),
      .in2_real     (in2_real),
      .in2_imag     (in2_imag),
      .twiddle_real (twiddle_real),
      .twiddle_imag (twiddle_imag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out1_real    (out1_real),
      .out1_imag    (out1_imag),
      .out2_real    (out2_real),
      .out2_imag    (out2_imag),
      .sat          (sat)
   );

   always #5 clk = ~clk;

   function automatic longint scl(input longint x);
`ifdef IFFT_SCALE_EN
      return (x + 1) >>> 1;
`else
      return x;
`endif
   endfunction

   function automatic longint clamp18(input longint x);
      if (x > 131071) return 131071;
      if (x < -131072) return -131072;
      return x;
   endfunction

   // Reference: sum path and (a-b)*conj(W) in Q1.14 with round-half-up, then clamp.
   function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                  input longint bi, input longint wr, input longint wi);
      exp_t   e;
      longint pr, pi;
      pr = ((ar - br) * wr + (ai - bi) * wi + 8192) >>> 14;
      pi = ((ai - bi) * wr - (ar - br) * wi + 8192) >>> 14;
      e.clip = (clamp18(pr) != pr) || (clamp18(pi) != pi);
      e.o1r  = scl(ar + br);
      e.o1i  = scl(ai + bi);
      e.o2r  = scl(clamp18(pr));
      e.o2i  = scl(clamp18(pi));
      return e;
   endfunction

   function automatic int rnd16();
      int v;
      v = int'($signed(16'($urandom)));
      if ($urandom_range(1, 0) == 1) v = v >>> 5;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         misses++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit v, input int ar, input int ai, input int br,
                                input int bi, input int wr, input int wi);
      in_valid     = v;
      in1_real     = ar[15:0];
      in1_imag     = ai[15:0];
      in2_real     = br[15:0];
      in2_imag     = bi[15:0];
      twiddle_real = wr[15:0];
      twiddle_imag = wi[15:0];
   endtask

   // Presents one pair and checks out_valid rises exactly on the third edge.
   task automatic latencyCheck(input string tag, input int ar, input int ai, input int br,
                               input int bi, input int wr, input int wi);
      applyStimulus(1'b1, ar, ai, br, bi, wr, wi);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput({tag, "_lat1"}, out_valid, 0);
      @(posedge clk); #1;
      checkOutput({tag, "_lat2"}, out_valid, 0);
      @(posedge clk); #1;
      checkOutput({tag, "_lat3"}, out_valid, 1);
   endtask

   // Monitor at the falling edge: handshakes, scoreboard, stall stability and sticky sat.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         expSat    = 1'b0;
         holdValid = 1'b0;
      end else begin
         checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
         if (holdValid) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_o1r", out1_real, held1r);
            checkOutput("hold_o1i", out1_imag, held1i);
            checkOutput("hold_o2r", out2_real, held2r);
            checkOutput("hold_o2i", out2_imag, held2i);
         end
         if (out_valid && expQ.size() == 0)
            checkOutput("unexpected_out", out_valid, 0);
         if (out_valid && expQ.size() > 0 && expQ[0].clip)
            expSat = 1'b1;
         checkOutput("sat_flag", sat, expSat);
         if (out_valid && out_ready && expQ.size() > 0) begin
            checkOutput("out1_real", out1_real, expQ[0].o1r);
            checkOutput("out1_imag", out1_imag, expQ[0].o1i);
            checkOutput("out2_real", out2_real, expQ[0].o2r);
            checkOutput("out2_imag", out2_imag, expQ[0].o2i);
            void'(expQ.pop_front());
            rxCount++;
         end
         holdValid = out_valid && !out_ready;
         held1r = out1_real;
         held1i = out1_imag;
         held2r = out2_real;
         held2i = out2_imag;
         if (in_valid && in_ready)
            expQ.push_back(model($signed(in1_real), $signed(in1_imag), $signed(in2_real),
                                 $signed(in2_imag), $signed(twiddle_real), $signed(twiddle_imag)));
      end
   end

   // Watchdog so a wedged pipe still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence followed by randomized traffic.
   initial begin
      int ar, ai, br, bi, wr, wi;
      int sent, cyc, rx0;
      bit newPair;

      rst       = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_sat", sat, 0);
      checkOutput("rst_o1r", out1_real, 0);
      checkOutput("rst_o1i", out1_imag, 0);
      checkOutput("rst_o2r", out2_real, 0);
      checkOutput("rst_o2i", out2_imag, 0);
      rst = 1'b0;

      latencyCheck("unit", 1, 0, 1, 0, 16384, 0);
      checkOutput("unit_o1r", out1_real, scl(2));
      checkOutput("unit_o1i", out1_imag, scl(0));
      checkOutput("unit_o2r", out2_real, 0);
      checkOutput("unit_o2i", out2_imag, 0);
      checkOutput("unit_sat", sat, 0);

      latencyCheck("real_w", 100, 50, 20, 10, 16384, 0);
      checkOutput("real_w_o1r", out1_real, scl(120));
      checkOutput("real_w_o1i", out1_imag, scl(60));
      checkOutput("real_w_o2r", out2_real, scl(80));
      checkOutput("real_w_o2i", out2_imag, scl(40));

      latencyCheck("conj_w", 100, 50, 20, 10, 0, 16384);
      checkOutput("conj_w_o2r", out2_real, scl(40));
      checkOutput("conj_w_o2i", out2_imag, scl(-80));
      @(posedge clk); #1;

      sent = 0; cyc = 0; newPair = 1'b1; rx0 = rxCount;
      while (sent < 8 && cyc < 100) begin
         if (newPair) begin
            ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
            wr = int'($signed(16'($urandom))); wi = int'($signed(16'($urandom)));
         end
         applyStimulus(1'b1, ar, ai, br, bi, wr, wi);
         out_ready = stallPat[cyc % 4];
         #1;
         newPair = in_ready;
         if (in_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      while (expQ.size() != 0 && cyc < 160) begin
         out_ready = stallPat[cyc % 4];
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
      checkOutput("stall_sent", sent, 8);
      checkOutput("stall_received", rxCount - rx0, 8);
      checkOutput("stall_drained", expQ.size(), 0);
      @(posedge clk); #1;

      latencyCheck("satur", 32767, 32767, -32768, -32768, -32768, -32768);
      checkOutput("satur_o2r", out2_real, scl(-131072));
      checkOutput("satur_o2i", out2_imag, scl(0));
      checkOutput("satur_sat", sat, 1);
      latencyCheck("sat_hold", 5, 5, 1, 1, 16384, 0);
      checkOutput("sat_hold_sat", sat, 1);
      @(posedge clk); #1;

      applyStimulus(1'b1, 300, -200, 100, 50, 16384, 0);
      @(posedge clk); #1;
      applyStimulus(1'b1, -7, 9, 3, -4, 0, 16384);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("flush_out_valid", out_valid, 0);
         checkOutput("flush_sat", sat, 0);
         checkOutput("flush_in_ready", in_ready, 1);
         @(posedge clk); #1;
      end
      latencyCheck("post_rst", 100, 50, 20, 10, 16384, 0);
      checkOutput("post_rst_o1r", out1_real, scl(120));
      @(posedge clk); #1;

      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(3, 0) != 0, rnd16(), rnd16(), rnd16(), rnd16(),
                       int'($signed(16'($urandom))), int'($signed(16'($urandom))));
         out_ready = $urandom_range(2, 0) != 0;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (expQ.size() != 0 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("random_drained", expQ.size(), 0);
      repeat (2) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
